stb_sweep: RTL
==============

Name: stb_sweep

Overview:
- Sits directly downstream of stb_gen in the measure unit.
- Consumes stb_gen's strobe, its measured period (stb_period_o, in clk_i cycles) and its rdy_o.
- Produces a delayed strobe whose delay is swept from 0 up to the period in programmable steps.
- At each delay point it samples the comparator N times, counts the ones, and reports one (delay, hits) point per step over a valid/ready handshake. Firmware uses these points to reconstruct the comparator transition.

Parameters:
T_CNT_WIDTH, 32, width of period, delay and step values (matches stb_gen)
CNT_WIDTH, 16, width of sample-count and hit-count values

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  pulse: begin sweep (accepted only in IDLE)
stb_i  in  1  strobe from stb_gen (stb_o); rising edge marks period start
stb_period_i  in  T_CNT_WIDTH  measured period from stb_gen, in clk_i cycles
rdy_i  in  1  stb_gen period-measurement ready
sig_i  in  1  comparator output, already synchronized to clk_i
step_i  in  T_CNT_WIDTH  delay increment per point, in clk_i cycles
n_samples_i  in  CNT_WIDTH  samples per point
busy_o  out  1  sweep in progress
dstb_o  out  1  delayed strobe, one-cycle pulse
pt_valid_o  out  1  point result valid
pt_ready_i  in  1  consumer accepts point
pt_delay_o  out  T_CNT_WIDTH  delay of reported point
pt_hits_o  out  CNT_WIDTH  count of sig_i==1 samples at that delay
done_o  out  1  one-cycle pulse: sweep complete
err_o  out  1  sticky error flag

Behaviour:
- Clock is clk_i; reset is rst_i, synchronous and active-high; single clock domain.
- Reset values: all outputs 0; state IDLE; D, hits, samples and the stb_i edge register cleared.
- rst_i asserted in any state returns to IDLE on the next edge. No point is emitted and done_o is not pulsed.
- States: IDLE, ARM, COUNT, REPORT.
- IDLE:
  - start_i=1 with rdy_i=1 latches P=stb_period_i, S=step_i, N=n_samples_i; clears err_o, D, hits and samples; goes to ARM; busy_o=1 from the next cycle.
  - If, at that start_i, rdy_i=0 or P=0 or S=0 or N=0: err_o=1 and the block stays in IDLE.
  - start_i is ignored in every state other than IDLE.
- ARM: the rising edge of stb_i is detected in cycle k (stb_i=1, previous stb_i=0). On that edge, load the countdown with D and go to COUNT.
- COUNT:
  - dstb_o=1 in exactly cycle k+1+D.
  - In the same cycle, sig_i is sampled: hits += sig_i and samples += 1.
  - If samples now equals N, go to REPORT; otherwise return to ARM.
- REPORT:
  - pt_valid_o=1, pt_delay_o=D, pt_hits_o=hits; these are held stable until pt_valid_o && pt_ready_i.
  - stb_i edges arriving in REPORT are ignored; no dstb_o, no sampling.
  - On handshake, compute D+S at T_CNT_WIDTH+1 bits (no wrap).
  - If D+S >= P: done_o pulses one cycle, go to IDLE, busy_o drops.
  - Otherwise: D = D+S, clear hits and samples, go to ARM.
- Overrun: a stb_i rising edge detected in COUNT before dstb_o fires sets err_o=1. That edge is ignored and the countdown continues.
- rdy_i falling to 0 in ARM, COUNT or REPORT means stb_gen was reset or re-armed:
  - err_o=1, go to IDLE.
  - pt_valid_o drops; the point is discarded; no done_o.
- err_o is sticky; it is cleared only by rst_i or by an accepted start_i.
- Width rules: hits never exceeds N < 2^CNT_WIDTH, so no saturation logic is needed. D < P always holds inside the sweep.
- The number of points per sweep is ceil(P/S).

Decomposition:
- Package stb_sweep_pkg: state enum type (IDLE, ARM, COUNT, REPORT) and a point struct {delay, hits} parameterised via localparams defaulting to T_CNT_WIDTH=32 and CNT_WIDTH=16.
- One sub-module, stb_delay_line: rising-edge detect on stb_i, load countdown D, emit a one-cycle pulse at k+1+D, and flag overrun. Sweep control and the handshake stay in stb_sweep.

Test Plan:
- P=10, S=3, N=4, sig_i=1 constant -> four points (delay,hits) = (0,4),(3,4),(6,4),(9,4); done_o pulse after the 4th handshake; err_o=0.
- Latency: D=0 then D=5 -> dstb_o rises exactly 1 and 6 cycles after the stb_i rising-edge detect cycle; hits match sig_i as driven low/high on those exact cycles.
- Backpressure: hold pt_ready_i=0 for 50 cycles across 3 stb_i edges -> pt_valid_o, pt_delay_o and pt_hits_o stable; dstb_o stays 0; after release, the next point starts counting from 0 hits.
- Boundary: S=P=8 -> a single point at delay 0, then done_o. Also: start_i with P=0, S=0, N=0 or rdy_i=0 -> err_o=1, busy_o stays 0, no dstb_o.
- Faults: drop rdy_i during COUNT -> err_o=1, IDLE, no done_o. Then start_i -> err_o clears and a new sweep runs normally. An stb_i edge injected 2 cycles after the detect with D=6 -> err_o=1 and dstb_o still fires at k+7.
- Reset: assert rst_i for 1 cycle during REPORT -> next cycle all outputs 0 and IDLE; start_i is accepted immediately afterwards.

Source files
------------

// File: rtl/stb_sweep_pkg.sv
// Shared types for the strobe delay sweep: controller states and the
// (delay, hits) point reported to firmware.
package stb_sweep_pkg;

    localparam int T_CNT_WIDTH = 32;
    localparam int CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT,
        REPORT
    } state_t;

    typedef struct packed {
        logic [T_CNT_WIDTH-1:0] delay;
        logic [CNT_WIDTH-1:0]   hits;
    } point_t;

endpackage

// File: rtl/stb_sweep_delay_line.sv
// Rising-edge detector on the incoming strobe plus a loadable countdown that
// emits a single registered pulse delay+1 cycles after the detected edge.
module stb_delay_line #(
    parameter int T_CNT_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stb,
    input  logic                   load,
    input  logic                   enable,
    input  logic [T_CNT_WIDTH-1:0] delay,
    output logic                   rise,
    output logic                   pulse,
    output logic                   overrun
);

    logic                   stb_q;
    logic                   pending;
    logic [T_CNT_WIDTH-1:0] cnt;

    assign rise    = stb & ~stb_q;
    assign overrun = rise & pending & enable;

    // Dropping enable (controller left COUNT) cancels any countdown in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q   <= 1'b0;
            pending <= 1'b0;
            pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            stb_q <= stb;
            if (load) begin
                cnt     <= delay;
                pending <= (delay != '0);
                pulse   <= (delay == '0);
            end else if (enable) begin
                pulse <= pending && (cnt == T_CNT_WIDTH'(1));
                if (pending) begin
                    cnt <= cnt - T_CNT_WIDTH'(1);
                    if (cnt == T_CNT_WIDTH'(1)) begin
                        pending <= 1'b0;
                    end
                end
            end else begin
                pending <= 1'b0;
                pulse   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stb_sweep.sv
// Sweeps a delayed copy of stb_gen's strobe across one period, counting
// comparator ones at each delay point and handing (delay, hits) to firmware.
module stb_sweep #(
    parameter int T_CNT_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   stb_i,
    input  logic [T_CNT_WIDTH-1:0] stb_period_i,
    input  logic                   rdy_i,
    input  logic                   sig_i,
    input  logic [T_CNT_WIDTH-1:0] step_i,
    input  logic [CNT_WIDTH-1:0]   n_samples_i,
    output logic                   busy_o,
    output logic                   dstb_o,
    output logic                   pt_valid_o,
    input  logic                   pt_ready_i,
    output logic [T_CNT_WIDTH-1:0] pt_delay_o,
    output logic [CNT_WIDTH-1:0]   pt_hits_o,
    output logic                   done_o,
    output logic                   err_o
);

    import stb_sweep_pkg::*;

    state_t                 state;
    logic [T_CNT_WIDTH-1:0] period;
    logic [T_CNT_WIDTH-1:0] step;
    logic [T_CNT_WIDTH-1:0] delay;
    logic [CNT_WIDTH-1:0]   n_samples;
    logic [CNT_WIDTH-1:0]   hits;
    logic [CNT_WIDTH-1:0]   samples;
    logic [CNT_WIDTH-1:0]   samples_inc;
    logic [T_CNT_WIDTH:0]   next_delay;
    logic                   rise;
    logic                   pulse;
    logic                   overrun;
    logic                   load;
    logic                   enable;

    // One extra bit so the end-of-sweep compare never sees a wrapped delay.
    assign next_delay  = {1'b0, delay} + {1'b0, step};
    assign samples_inc = samples + CNT_WIDTH'(1);
    assign load        = (state == ARM) && rdy_i && rise;
    assign enable      = (state == COUNT) && rdy_i;

    assign dstb_o     = pulse;
    assign pt_delay_o = delay;
    assign pt_hits_o  = hits;

    stb_delay_line #(
        .T_CNT_WIDTH(T_CNT_WIDTH)
    ) u_delay_line (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stb     (stb_i),
        .load    (load),
        .enable  (enable),
        .delay   (delay),
        .rise    (rise),
        .pulse   (pulse),
        .overrun (overrun)
    );

    // Losing rdy_i in any active state means stb_gen restarted under us.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            period     <= '0;
            step       <= '0;
            delay      <= '0;
            n_samples  <= '0;
            hits       <= '0;
            samples    <= '0;
            busy_o     <= 1'b0;
            pt_valid_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        if (rdy_i && (stb_period_i != '0) && (step_i != '0) && (n_samples_i != '0)) begin
                            period    <= stb_period_i;
                            step      <= step_i;
                            n_samples <= n_samples_i;
                            delay     <= '0;
                            hits      <= '0;
                            samples   <= '0;
                            err_o     <= 1'b0;
                            busy_o    <= 1'b1;
                            state     <= ARM;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (!rdy_i) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (rise) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!rdy_i) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (overrun) begin
                            err_o <= 1'b1;
                        end
                        if (pulse) begin
                            hits    <= hits + CNT_WIDTH'(sig_i);
                            samples <= samples_inc;
                            if (samples_inc == n_samples) begin
                                pt_valid_o <= 1'b1;
                                state      <= REPORT;
                            end else begin
                                state <= ARM;
                            end
                        end
                    end
                end
                REPORT: begin
                    if (!rdy_i) begin
                        err_o      <= 1'b1;
                        busy_o     <= 1'b0;
                        pt_valid_o <= 1'b0;
                        state      <= IDLE;
                    end else if (pt_ready_i) begin
                        pt_valid_o <= 1'b0;
                        if (next_delay >= {1'b0, period}) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            delay   <= next_delay[T_CNT_WIDTH-1:0];
                            hits    <= '0;
                            samples <= '0;
                            state   <= ARM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
